// File: rtl/isqrt_128b_pkg.sv
// rtl/isqrt_128b_pkg.sv - shared types and sizing for the integer square root
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry: 128-bit radicand, one root bit per clock.
    localparam int IN_W  = 128;
    localparam int OUT_W = IN_W / 2;
    localparam int STEPS = 1;
    localparam int ITERS = OUT_W / STEPS;
    localparam int CNT_W = $clog2(ITERS);

    // Counter width for a given iteration count, never narrower than one bit.
    function automatic int cnt_width(input int iters);
        return (iters > 1) ? $clog2(iters) : 1;
    endfunction

endpackage

// File: rtl/isqrt_128b_if.sv
// rtl/isqrt_128b_if.sv - radicand/result handshake bundle for isqrt_128b
interface isqrt_128b_if #(
    parameter int IN_W = 128
);
    localparam int OUT_W = IN_W / 2;

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in0;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out0;
    logic [OUT_W:0]     rem;

    // The square-root engine side.
    modport slave (
        input  in_valid,
        input  in0,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out0,
        output rem
    );

    // The producer/consumer side.
    modport master (
        output in_valid,
        output in0,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out0,
        input  rem
    );

endinterface

// File: rtl/isqrt_128b_step.sv
// rtl/isqrt_128b_step.sv - one restoring digit-by-digit square root iteration
module isqrt_step #(
    parameter int RW = 64
) (
    input  logic [RW+1:0] r_in,
    input  logic [RW-1:0] q_in,
    input  logic [1:0]    x_in,
    output logic [RW+1:0] r_out,
    output logic [RW-1:0] q_out
);

    logic [RW+1:0] r_sh;
    logic [RW+1:0] trial;
    logic          fits;

    // The incoming partial remainder never exceeds RW bits, so shifting it
    // by two within RW+2 bits loses nothing.
    assign r_sh  = (r_in << 2) | {{RW{1'b0}}, x_in};
    assign trial = {q_in, 2'b01};
    assign fits  = (r_sh >= trial);

    assign r_out = fits ? (r_sh - trial) : r_sh;
    assign q_out = (q_in << 1) | {{(RW-1){1'b0}}, fits};

endmodule

// File: rtl/isqrt_128b.sv
// rtl/isqrt_128b.sv - sequential 128-bit integer square root with remainder
module isqrt_128b
    import isqrt_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int STEPS = 1
) (
    input  logic         clk,
    input  logic         rst,
    isqrt_128b_if.slave  bus,
    output logic         busy
);

    localparam int RW     = IN_W / 2;
    localparam int N_ITER = RW / STEPS;
    localparam int CW     = cnt_width(N_ITER);

    state_t           state;
    state_t           state_nxt;

    logic [IN_W-1:0]  x;
    logic [RW+1:0]    r;
    logic [RW-1:0]    q;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    res_q;
    logic [RW:0]      res_r;

    logic [RW+1:0]    r_n;
    logic [RW-1:0]    q_n;

    // STEPS chained iterations, each consuming the next radicand bit pair.
    for (genvar g = 0; g < STEPS; g++) begin : stg
        logic [RW+1:0] r_i;
        logic [RW+1:0] r_o;
        logic [RW-1:0] q_i;
        logic [RW-1:0] q_o;

        if (g == 0) begin : g_first
            assign r_i = r;
            assign q_i = q;
        end else begin : g_next
            assign r_i = stg[g-1].r_o;
            assign q_i = stg[g-1].q_o;
        end

        isqrt_step #(.RW(RW)) u_step (
            .r_in  (r_i),
            .q_in  (q_i),
            .x_in  (x[IN_W-1-2*g -: 2]),
            .r_out (r_o),
            .q_out (q_o)
        );
    end

    assign r_n = stg[STEPS-1].r_o;
    assign q_n = stg[STEPS-1].q_o;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: accept, iterate until the counter expires, hand off.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)   state_nxt = CALC;
            CALC:    if (cnt == '0)      state_nxt = DONE;
            DONE:    if (bus.out_ready)  state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Radicand shifter, partial remainder/root, iteration counter and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            x     <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            res_q <= '0;
            res_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x   <= bus.in0;
                        r   <= '0;
                        q   <= '0;
                        cnt <= CW'(N_ITER - 1);
                    end
                end
                CALC: begin
                    x <= x << (2 * STEPS);
                    r <= r_n;
                    q <= q_n;
                    if (cnt == '0) begin
                        res_q <= q_n;
                        res_r <= r_n[RW:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out0 = res_q;
    assign bus.rem  = res_r;

endmodule

// File: tb/tb_isqrt_128b.sv
// tb/tb_isqrt_128b.sv - scoreboard bench for isqrt_128b at STEPS=1 and STEPS=4
module tb_isqrt_128b;

    typedef struct packed {
        logic [127:0] x;
        logic [63:0]  q;
        logic [64:0]  r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic busy4;

    isqrt_128b_if #(.IN_W(128)) bus  ();
    isqrt_128b_if #(.IN_W(128)) bus4 ();

    isqrt_128b #(.IN_W(128), .STEPS(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    isqrt_128b #(.IN_W(128), .STEPS(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus4),
        .busy (busy4)
    );

    always #5 clk = ~clk;

    exp_t sb1[$];
    exp_t sb4[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] MAX_IN  = {128{1'b1}};
    localparam logic [63:0]  MAX_Q   = {64{1'b1}};
    localparam logic [64:0]  MAX_R   = 65'h1_FFFF_FFFF_FFFF_FFFE;
    localparam logic [127:0] SQ_MAXQ = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_result(input string tag, input exp_t e,
                                  input logic [63:0] q, input logic [64:0] r);
        logic [129:0] sq;
        sq = ({66'd0, q} * {66'd0, q}) + {65'd0, r};
        check({tag, "_out0"}, {66'd0, q}, {66'd0, e.q});
        check({tag, "_rem"}, {65'd0, r}, {65'd0, e.r});
        check({tag, "_identity"}, sq, {2'b00, e.x});
        check({tag, "_rem_bound"}, {129'd0, ({1'b0, r} <= {1'b0, q, 1'b0})}, 130'd1);
    endtask

    // Scoreboard monitor for the STEPS=1 instance.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb1.size() == 0) begin
                check("s1_unexpected_result", 130'd1, 130'd0);
            end else begin
                compare_result("s1", sb1.pop_front(), bus.out0, bus.rem);
            end
        end
    end

    // Scoreboard monitor for the STEPS=4 instance.
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            if (sb4.size() == 0) begin
                check("s4_unexpected_result", 130'd1, 130'd0);
            end else begin
                compare_result("s4", sb4.pop_front(), bus4.out0, bus4.rem);
            end
        end
    end

    function automatic logic ir(input bit s);
        return s ? bus4.in_ready : bus.in_ready;
    endfunction

    function automatic logic ov(input bit s);
        return s ? bus4.out_valid : bus.out_valid;
    endfunction

    task automatic drive_in(input bit s, input logic v, input logic [127:0] d);
        if (s) begin
            bus4.in_valid = v;
            bus4.in0      = d;
        end else begin
            bus.in_valid = v;
            bus.in0      = d;
        end
    endtask

    // Wait for in_ready, present one radicand for a single edge.
    task automatic accept(input bit s, input string tag, input logic [127:0] v);
        int k;
        k = 0;
        while (!ir(s) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_in_ready_before"}, {129'd0, ir(s)}, 130'd1);
        drive_in(s, 1'b1, v);
        @(posedge clk); #1;
        drive_in(s, 1'b0, '0);
    endtask

    // Full transaction with out_ready high: latency and release checks.
    task automatic run_one(input bit s, input string tag, input logic [127:0] v,
                           input logic [63:0] q, input logic [64:0] r, input int lat_exp);
        int   lat;
        exp_t e;
        e.x = v;
        e.q = q;
        e.r = r;
        accept(s, tag, v);
        if (s) sb4.push_back(e);
        else   sb1.push_back(e);
        lat = 1;
        while (!ov(s) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 130'(lat), 130'(lat_exp));
        @(posedge clk); #1;
        check({tag, "_in_ready_after"}, {129'd0, ir(s)}, 130'd1);
        check({tag, "_out_valid_after"}, {129'd0, ov(s)}, 130'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   extra;
        exp_t e;

        drive_in(1'b0, 1'b0, '0);
        drive_in(1'b1, 1'b0, '0);
        bus.out_ready  = 1'b1;
        bus4.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {129'd0, bus.in_ready}, 130'd1);
        check("rst_out_valid", {129'd0, bus.out_valid}, 130'd0);
        check("rst_busy", {129'd0, busy}, 130'd0);
        check("rst_out0", {66'd0, bus.out0}, 130'd0);
        check("rst_rem", {65'd0, bus.rem}, 130'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, STEPS=1
        run_one(1'b0, "zero",   128'd0, 64'd0, 65'd0, 65);
        run_one(1'b0, "n99",    128'd99, 64'd9, 65'd18, 65);
        run_one(1'b0, "p2_126", 128'd1 << 126, 64'd1 << 63, 65'd0, 65);
        run_one(1'b0, "max",    MAX_IN, MAX_Q, MAX_R, 65);
        run_one(1'b0, "n3",     128'd3, 64'd1, 65'd2, 65);
        run_one(1'b0, "sqmax",  SQ_MAXQ, MAX_Q, 65'd0, 65);
        run_one(1'b0, "e20",    128'd100000000000000000000, 64'd10000000000, 65'd0, 65);

        // Backpressure in DONE, stray in_valid in CALC and DONE
        bus.out_ready = 1'b0;
        accept(1'b0, "bp", 128'd1000000);
        e.x = 128'd1000000;
        e.q = 64'd1000;
        e.r = 65'd0;
        sb1.push_back(e);
        repeat (10) @(posedge clk);
        #1;
        drive_in(1'b0, 1'b1, 128'd5);
        repeat (3) @(posedge clk);
        #1;
        drive_in(1'b0, 1'b0, '0);
        k = 0;
        while (!bus.out_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        drive_in(1'b0, 1'b1, 128'd5);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {129'd0, bus.out_valid}, 130'd1);
            check("bp_in_ready", {129'd0, bus.in_ready}, 130'd0);
            check("bp_out0", {66'd0, bus.out0}, 130'd1000);
            check("bp_rem", {65'd0, bus.rem}, 130'd0);
        end
        drive_in(1'b0, 1'b0, '0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_out_valid", {129'd0, bus.out_valid}, 130'd0);
        check("bp_released_in_ready", {129'd0, bus.in_ready}, 130'd1);
        check("bp_held_out0", {66'd0, bus.out0}, 130'd1000);
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) extra++;
        end
        check("no_second_result", 130'(extra), 130'd0);

        // Reset in the middle of CALC discards the computation
        accept(1'b0, "rstmid", 128'd99);
        repeat (30) @(posedge clk);
        #1;
        check("rstmid_busy_before", {129'd0, busy}, 130'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_busy", {129'd0, busy}, 130'd0);
        check("rstmid_in_ready", {129'd0, bus.in_ready}, 130'd1);
        check("rstmid_out_valid", {129'd0, bus.out_valid}, 130'd0);
        check("rstmid_out0", {66'd0, bus.out0}, 130'd0);
        check("rstmid_rem", {65'd0, bus.rem}, 130'd0);
        run_one(1'b0, "n16", 128'd16, 64'd4, 65'd0, 65);

        // STEPS=4 instance
        run_one(1'b1, "s4_max", MAX_IN, MAX_Q, MAX_R, 17);
        run_one(1'b1, "s4_n99", 128'd99, 64'd9, 65'd18, 17);
        run_one(1'b1, "s4_n2",  128'd2, 64'd1, 65'd1, 17);

        repeat (5) @(posedge clk);
        #1;
        check("sb1_drained", 130'(sb1.size()), 130'd0);
        check("sb4_drained", 130'(sb4.size()), 130'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
